// File: rtl/cacheline_adaptor.sv
// Bridges a cache-line request to a four-beat memory burst.
// Read beats are assembled into line_o; writeback lines are streamed out on burst_o.
module cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int BEATS   = LINE_W / BURST_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               resp_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [1:0] LAST = 2'(BEATS - 1);

   state_t              state;
   logic [1:0]          cnt;
   logic [31:0]         addr_q;
   logic [LINE_W-1:0]   wline_q;
   logic [LINE_W-1:0]   rline_q;

   // The write line and address are captured only at acceptance, so requester changes mid-burst are invisible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         addr_q  <= 32'd0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i) begin
                  wline_q <= line_i;
                  addr_q  <= address_i;
                  cnt     <= 2'd0;
                  state   <= WRITE;
               end else if (read_i) begin
                  addr_q  <= address_i;
                  cnt     <= 2'd0;
                  state   <= READ;
               end
            end
            READ: begin
               if (resp_i) begin
                  rline_q[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
                  cnt <= cnt + 2'd1;
                  if (cnt == LAST) state <= DONE;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  cnt <= cnt + 2'd1;
                  if (cnt == LAST) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign read_o    = (state == READ);
   assign write_o   = (state == WRITE);
   assign resp_o    = (state == DONE);
   assign address_o = {addr_q[31:5], 5'b0};
   assign line_o    = rline_q;
   assign burst_o   = (state == WRITE) ? wline_q[int'(cnt)*BURST_W +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected lines and write beats are queued
// when a request is driven and popped when the DUT signals completion or accepts a beat.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic         resp_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic [63:0]  burst_o;
   logic [63:0]  burst_i;
   logic         resp_i;

   int passCount  = 0;
   int checkCount = 0;
   int respCount  = 0;

   logic [255:0] lineQ[$];
   logic [63:0]  beatQ[$];
   logic [255:0] modelLine = '0;

   always #5 clk = ~clk;

   cacheline_adaptor dut (
      .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
      .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
   );

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Completion and write-beat scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_o) begin
            respCount++;
            if (lineQ.size() == 0) checkOutput("resp_unexpected", 1, 0);
            else checkOutput("line_o", line_o, lineQ.pop_front());
         end
         if (write_o && resp_i) begin
            if (beatQ.size() == 0) checkOutput("beat_unexpected", 1, 0);
            else checkOutput("burst_o", burst_o, beatQ.pop_front());
         end
      end
   end

   // Runs one line transaction; respPat bit i is resp_i in burst cycle i (1 beyond patLen).
   task automatic applyStimulus(input bit doRead, input bit doWrite, input logic [31:0] addr,
                                input logic [255:0] wline, input logic [255:0] rline,
                                input logic [15:0] respPat, input int patLen, input int expBusy);
      int beats = 0;
      int busy  = 0;
      int i     = 0;
      bit r;
      logic [31:0] expAddr;
      expAddr   = {addr[31:5], 5'b0};
      address_i = addr;
      read_i    = doRead;
      write_i   = doWrite;
      line_i    = wline;
      if (doWrite) begin
         for (int k = 0; k < 4; k++) beatQ.push_back(wline[k*64 +: 64]);
      end else begin
         modelLine = rline;
      end
      lineQ.push_back(modelLine);
      @(posedge clk); #1;
      line_i    = ~wline;
      address_i = ~addr;
      while (beats < 4 && i < 40) begin
         r       = (i < patLen) ? respPat[i] : 1'b1;
         resp_i  = r;
         burst_i = r ? rline[beats*64 +: 64] : $urandom();
         busy   += int'(read_o | write_o);
         checkOutput("read_o_busy", read_o, !doWrite);
         checkOutput("write_o_busy", write_o, doWrite);
         checkOutput("address_o", address_o, expAddr);
         if (doWrite && !r) checkOutput("burst_stall", burst_o, wline[beats*64 +: 64]);
         @(posedge clk); #1;
         if (r) beats++;
         i++;
      end
      if (beats < 4) checkOutput("beat_timeout", beats, 4);
      resp_i = 1'b0;
      checkOutput("busy_cycles", busy, expBusy);
      checkOutput("resp_pulse", resp_o, 1);
      checkOutput("done_idle_rw", {read_o, write_o}, 2'b00);
      read_i  = 1'b0;
      write_i = 1'b0;
      @(posedge clk); #1;
      checkOutput("resp_single", resp_o, 0);
      checkOutput("burst_idle", burst_o, 0);
   endtask

   initial begin
      logic [255:0] patP;
      logic [255:0] rlineA;
      logic [255:0] rlineB;
      rst = 1'b1; address_i = '0; read_i = 0; write_i = 0; line_i = '0; burst_i = '0; resp_i = 0;
      #1;
      checkOutput("rst_read_o", read_o, 0);
      checkOutput("rst_write_o", write_o, 0);
      checkOutput("rst_resp_o", resp_o, 0);
      checkOutput("rst_address_o", address_o, 0);
      checkOutput("rst_burst_o", burst_o, 0);
      checkOutput("rst_line_o", line_o, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      rlineA = {64'hDDDDDDDDDDDDDDD3, 64'hCCCCCCCCCCCCCCC2, 64'hBBBBBBBBBBBBBBB1, 64'hAAAAAAAAAAAAAAA0};
      applyStimulus(1, 0, 32'h12345678, '0, rlineA, 16'hFFFF, 0, 4);
      checkOutput("addr_const", address_o, 32'h12345660);

      patP = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h5A5A5A5AA5A5A5A5, 64'h0F0F0F0FF0F0F0F0};
      applyStimulus(0, 1, 32'hCAFE_F00D, patP, '0, 16'b1011001, 7, 7);
      checkOutput("line_after_write", line_o, rlineA);

      applyStimulus(1, 1, 32'h0000_0FFF, ~patP, '0, 16'hFFFF, 0, 4);

      // Idle resp_i pulses must not start anything.
      for (int k = 0; k < 3; k++) begin
         resp_i = 1'b1; burst_i = $urandom();
         @(posedge clk); #1;
         checkOutput("idle_rw", {read_o, write_o, resp_o}, 3'b000);
      end
      resp_i = 1'b0;
      checkOutput("idle_line_o", line_o, rlineA);

      // Reset after two read beats.
      address_i = 32'h8000_0040; read_i = 1'b1;
      @(posedge clk); #1;
      resp_i = 1'b1; burst_i = 64'h1111_1111_1111_1111;
      @(posedge clk); #1;
      burst_i = 64'h2222_2222_2222_2222;
      @(posedge clk); #1;
      resp_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_read_o", read_o, 0);
      checkOutput("abort_line_o", line_o, 0);
      checkOutput("abort_resp_o", resp_o, 0);
      checkOutput("abort_address_o", address_o, 0);
      read_i = 1'b0;
      modelLine = '0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      rlineB = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(1, 0, 32'h0000_1234, '0, rlineB, 16'b11011, 5, 5);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("resp_total", respCount, 4);
      checkOutput("queues_empty", lineQ.size() + beatQ.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
